// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Word-organised synchronous data memory acting as the responder end of the
//   processor memory interface. After every reset it self-fills each word with
//   FILL_BASE + idx*FILL_STEP and holds rdy high until the fill completes.
//   In READY it serves one access per cycle. Reads are registered and
//   read-first, and writes are optional.
//
// Ports
//   clock   : single clock, rising edge
//   rst     : synchronous active-high reset; restarts the fill
//   address : byte address; word index = address[DEPTH_LOG2+1:2]
//   data    : 32-bit write data
//   wren    : write enable (honoured only in READY)
//   q       : registered read data (0 during reset/fill)
//   rdy     : busy flag, high during reset and fill
module data_mem_responder #(
   parameter int          ADDR_W     = 16,
   parameter int          DEPTH_LOG2 = 8,
   parameter logic [31:0] FILL_BASE  = 32'h0000_0000,
   parameter logic [31:0] FILL_STEP  = 32'h0000_0000
) (
   input  logic              clock,
   input  logic              rst,
   input  logic [ADDR_W-1:0] address,
   input  logic [31:0]       data,
   input  logic              wren,
   output logic [31:0]       q,
   output logic              rdy
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic {
      ST_FILL  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t                r_state = ST_FILL;
   state_t                w_next_state;
   logic [DEPTH_LOG2-1:0] r_idx   = '0;
   logic                  r_rdy   = 1'b1;
   logic [31:0]           r_q     = '0;
   logic [31:0]           r_mem [DEPTH];

   logic [DEPTH_LOG2-1:0] w_word;
   logic                  w_fill_we;
   logic                  w_access;
   logic [31:0]           w_fill_data;
   logic                  w_unused_addr;

   // Only the word-index bits matter; byte-offset and alias bits are dropped.
   assign w_word        = address[DEPTH_LOG2+1:2];
   assign w_unused_addr = ^address;

   // State register
   always_ff @(posedge clock) begin
      if (rst) begin
         r_state <= ST_FILL;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      if (rst) begin
         w_next_state = ST_FILL;
      end else if (r_state == ST_FILL && r_idx == DEPTH_LOG2'(DEPTH - 1)) begin
         w_next_state = ST_READY;
      end
   end

   // Output / control decode
   always_comb begin
      w_fill_we   = 1'b0;
      w_access    = 1'b0;
      w_fill_data = FILL_BASE + (32'(r_idx) * FILL_STEP);
      if (!rst) begin
         w_fill_we = (r_state == ST_FILL);
         w_access  = (r_state == ST_READY);
      end
   end

   // Fill index, busy flag and read register
   always_ff @(posedge clock) begin
      if (rst) begin
         r_idx <= '0;
         r_rdy <= 1'b1;
         r_q   <= '0;
      end else begin
         if (w_fill_we) begin
            r_idx <= r_idx + 1'b1;
         end
         // Busy clears on the same edge that writes the last fill word.
         r_rdy <= (w_next_state == ST_FILL);
         if (w_access) begin
            r_q <= r_mem[w_word];
         end else begin
            r_q <= '0;
         end
      end
   end

   // Storage array. There is no reset, so it can map onto block RAM.
   always_ff @(posedge clock) begin
      if (w_fill_we) begin
         r_mem[r_idx] <= w_fill_data;
      end else if (w_access && wren) begin
         r_mem[w_word] <= data;
      end
   end

   assign q   = r_q;
   assign rdy = r_rdy;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

   localparam int DEPTH = 16;

   logic        clock = 1'b0;
   logic        rst   = 1'b0;
   logic [15:0] address = '0;
   logic [31:0] data    = '0;
   logic        wren    = 1'b0;
   logic [31:0] q;
   logic        rdy;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // Behavioural reference: fill progress is a countdown of remaining fill edges.
   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_q    = '0;
   logic        m_rdy  = 1'b1;
   int          m_fill_left = DEPTH;

   data_mem_responder #(
      .ADDR_W    (16),
      .DEPTH_LOG2(4),
      .FILL_BASE (32'h100),
      .FILL_STEP (32'h4)
   ) dut (
      .clock  (clock),
      .rst    (rst),
      .address(address),
      .data   (data),
      .wren   (wren),
      .q      (q),
      .rdy    (rdy)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] pattern(input int i);
      return 32'h100 + 32'(i) * 32'h4;
   endfunction

   task automatic model_edge();
      int w;
      w = int'(address) / 4 % DEPTH;
      if (rst) begin
         m_fill_left = DEPTH;
         m_rdy = 1'b1;
         m_q   = '0;
      end else if (m_fill_left > 0) begin
         m_mem[DEPTH - m_fill_left] = pattern(DEPTH - m_fill_left);
         m_fill_left = m_fill_left - 1;
         m_rdy = (m_fill_left > 0);
         m_q   = '0;
      end else begin
         m_q = m_mem[w];
         if (wren) m_mem[w] = data;
      end
   endtask

   // Drive one set of inputs, take one rising edge, advance the model.
   task automatic cycle(input logic r, input logic w, input logic [15:0] a, input logic [31:0] d);
      rst = r; wren = w; address = a; data = d;
      @(posedge clock);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      #1;
      n_checks++;
      if (rdy !== 1'b1 || q !== 32'h0) begin
         n_fail++;
         $display("FAIL powerup: rdy=%b q=%h, want rdy=1 q=0", rdy, q);
      end
      for (int i = 0; i < 2; i++) begin
         cycle(1'b1, 1'b0, 16'h0, 32'h0);
         n_checks++;
         if (rdy !== 1'b1 || q !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_hold%0d: rdy=%b q=%h, want rdy=1 q=0", i, rdy, q);
         end
      end
   endtask

   task automatic test_fill();
      for (int i = 1; i <= DEPTH; i++) begin
         cycle(1'b0, 1'b0, 16'h0, 32'h0);
         n_checks++;
         if (rdy !== (i < DEPTH) || q !== 32'h0) begin
            n_fail++;
            $display("FAIL fill_edge%0d: rdy=%b q=%h, want rdy=%b q=0", i, rdy, q, (i < DEPTH));
         end
      end
      cycle(1'b0, 1'b0, 16'h0014, 32'h0);
      n_checks++;
      if (q !== 32'h114) begin
         n_fail++;
         $display("FAIL fill_read14: q=%h want 00000114", q);
      end
      cycle(1'b0, 1'b0, 16'h003C, 32'h0);
      n_checks++;
      if (q !== 32'h13C) begin
         n_fail++;
         $display("FAIL fill_read3c: q=%h want 0000013c", q);
      end
   endtask

   task automatic test_write_read();
      cycle(1'b0, 1'b1, 16'h0008, 32'hDEADBEEF);
      n_checks++;
      if (q !== 32'h108) begin
         n_fail++;
         $display("FAIL read_first: q=%h want 00000108", q);
      end
      cycle(1'b0, 1'b0, 16'h0008, 32'h0);
      n_checks++;
      if (q !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL write_visible: q=%h want deadbeef", q);
      end
   endtask

   task automatic test_alias();
      cycle(1'b0, 1'b1, 16'h0040, 32'hA5A5A5A5);
      n_checks++;
      if (q !== 32'h100) begin
         n_fail++;
         $display("FAIL alias_write_old: q=%h want 00000100", q);
      end
      cycle(1'b0, 1'b0, 16'h0000, 32'h0);
      n_checks++;
      if (q !== 32'hA5A5A5A5) begin
         n_fail++;
         $display("FAIL alias_read0: q=%h want a5a5a5a5", q);
      end
      cycle(1'b0, 1'b0, 16'h0003, 32'h0);
      n_checks++;
      if (q !== 32'hA5A5A5A5) begin
         n_fail++;
         $display("FAIL misalign_read3: q=%h want a5a5a5a5", q);
      end
   endtask

   task automatic test_write_during_fill();
      cycle(1'b1, 1'b1, 16'h0000, 32'hFFFFFFFF);
      for (int i = 1; i <= DEPTH; i++) begin
         cycle(1'b0, 1'b1, 16'h0000, 32'hFFFFFFFF);
         n_checks++;
         if (q !== 32'h0 || rdy !== (i < DEPTH)) begin
            n_fail++;
            $display("FAIL wfill_edge%0d: q=%h rdy=%b, want q=0 rdy=%b", i, q, rdy, (i < DEPTH));
         end
      end
      cycle(1'b0, 1'b0, 16'h0000, 32'h0);
      n_checks++;
      if (q !== 32'h100) begin
         n_fail++;
         $display("FAIL wfill_read0: q=%h want 00000100", q);
      end
   endtask

   task automatic test_reset_mid();
      cycle(1'b1, 1'b0, 16'h0, 32'h0);
      for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 16'h0, 32'h0);
      cycle(1'b1, 1'b0, 16'h0, 32'h0);
      n_checks++;
      if (rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL midfill_rst: rdy=%b want 1", rdy);
      end
      for (int i = 1; i <= DEPTH; i++) begin
         cycle(1'b0, 1'b0, 16'h0, 32'h0);
         n_checks++;
         if (rdy !== (i < DEPTH)) begin
            n_fail++;
            $display("FAIL refill_edge%0d: rdy=%b want %b", i, rdy, (i < DEPTH));
         end
      end
      cycle(1'b0, 1'b1, 16'h0010, 32'h12345678);
      cycle(1'b0, 1'b0, 16'h0010, 32'h0);
      n_checks++;
      if (q !== 32'h12345678) begin
         n_fail++;
         $display("FAIL ready_write10: q=%h want 12345678", q);
      end
      cycle(1'b1, 1'b1, 16'h0010, 32'hCAFEF00D);
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 16'h0, 32'h0);
      n_checks++;
      if (rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_after_rst: rdy=%b want 0", rdy);
      end
      cycle(1'b0, 1'b0, 16'h0010, 32'h0);
      n_checks++;
      if (q !== 32'h110) begin
         n_fail++;
         $display("FAIL rst_restores10: q=%h want 00000110", q);
      end
   endtask

   task automatic test_pipelined();
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b0, 16'(i * 4), 32'h0);
         n_checks++;
         if (q !== pattern(i)) begin
            n_fail++;
            $display("FAIL pipe_read%0d: q=%h want %h", i, q, pattern(i));
         end
      end
   endtask

   task automatic test_random();
      logic r, w;
      for (int i = 0; i < 300; i++) begin
         r = ($urandom_range(0, 59) == 0);
         w = $urandom_range(0, 1) == 1;
         cycle(r, w, 16'($urandom), $urandom);
         n_checks++;
         if (q !== m_q || rdy !== m_rdy) begin
            n_fail++;
            $display("FAIL random%0d: q=%h rdy=%b, want q=%h rdy=%b", i, q, rdy, m_q, m_rdy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_write_read();
      test_alias();
      test_write_during_fill();
      test_reset_mid();
      test_pipelined();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Word-organised synchronous data memory serving as the responder end of the processor's memory interface. The processor drives `address`, `data`, `wren` and the memory reset. This block returns registered read data on `q` and a busy indication on `rdy`. After every reset it runs a self-fill sequence that writes a deterministic pattern into every word, and it reports busy until the fill completes. It is instantiated as the data memory, and the instruction memory uses the same block with `wren` tied low.

## Interface
Parameters:
- `ADDR_W`, 16: width of the byte address port.
- `DEPTH_LOG2`, 8: log2 of the word count; DEPTH = 2^DEPTH_LOG2 words of 32 bits. Requires DEPTH_LOG2 + 2 <= ADDR_W.
- `FILL_BASE`, 32'h0000_0000: value written to word 0 during fill.
- `FILL_STEP`, 32'h0000_0000: increment between consecutive fill words.

Ports:
- `clock`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: synchronous, active-high reset; also restarts the fill.
- `address`, in, ADDR_W: byte address; word index = address[DEPTH_LOG2+1:2].
- `data`, in, 32: write data.
- `wren`, in, 1: write enable, sampled at the clock edge.
- `q`, out, 32: registered read data.
- `rdy`, out, 1: high while the block is busy (reset or fill); low when accesses are accepted. The processor computes ready as the AND of the inverted `rdy` outputs of both memories.

## Operation
- Two states: FILL and READY. The power-up initial value of the state register is FILL with fill index 0 and `rdy`=1.
- While `rst`=1 at an edge:
  - state goes to FILL; fill index goes to 0; `rdy` goes to 1; `q` goes to 0.
  - No memory write occurs.
- FILL, with `rst`=0 at an edge:
  - writes mem[idx] = FILL_BASE + idx*FILL_STEP, computed modulo 2^32 (32-bit wrapping add; idx is zero-extended).
  - increments idx.
  - on the edge that writes idx = DEPTH-1, the state goes to READY and `rdy` goes to 0.
- FILL ignores external inputs: `wren`, `address` and `data` are ignored, and `q` is held at 0.
- READY, with `rst`=0 at an edge:
  - `q` loads mem[word index].
  - if `wren`=1, mem[word index] loads `data`.
  - Read-first: on a write edge, `q` returns the pre-write contents.
- Address handling:
  - Bits address[1:0] are ignored, so misaligned addresses access the containing word.
  - Bits above DEPTH_LOG2+1 are ignored, so addresses alias modulo DEPTH*4 bytes.
  - No error is flagged in either case.
- `rst` asserted mid-fill or in READY:
  - fill restarts from word 0 and all contents are rewritten with the pattern.
  - any pending write on that edge is dropped.

## Timing
- Reset values: `q`=0, `rdy`=1, state FILL, idx 0.
- Fill duration:
  - `rdy` stays 1 on every edge where `rst`=1.
  - after `rst` falls, `rdy` drops to 0 after exactly DEPTH further rising edges.
  - the first access is accepted on edge DEPTH+1 after release.
- Read latency is 1 cycle: an address presented before edge N appears on `q` right after edge N. Back-to-back reads run at one per cycle.
- Write latency:
  - a write sampled at edge N is visible to a read sampled at edge N+1.
  - a read of the same address at edge N returns the old value.
- `q` holds its last value in READY when no new edge changes it. It loads on every READY edge, with no separate read enable.
- Simultaneous `rst` and `wren`: `rst` wins; no write occurs.

## Test plan
Bench configuration: DEPTH_LOG2=4, ADDR_W=16, FILL_BASE=32'h100, FILL_STEP=4.

1. Fill sequence:
   - Stimulus: hold `rst`=1 for 2 cycles, then release.
   - Required: `rdy`=1 for 16 edges after release, then 0; `q`=0 throughout.
   - Then read 0x0014 -> `q`=0x114 one cycle later; read 0x003C -> `q`=0x13C.
2. Write then read:
   - Stimulus: write 0xDEADBEEF to 0x0008.
   - Required: `q`=0x108 on that edge (read-first); the next-cycle read of 0x0008 gives 0xDEADBEEF.
3. Aliasing and misalignment:
   - Stimulus: write 0xA5A5A5A5 to 0x0040.
   - Required: reads of 0x0000 and 0x0003 each return 0xA5A5A5A5.
4. Write during fill:
   - Stimulus: `wren`=1, address 0x0000, data 0xFFFFFFFF on every fill cycle.
   - Required: after `rdy` falls, read 0x0000 gives 0x100; `q`=0 during fill.
5. Reset mid-operation:
   - Stimulus: assert `rst` at fill cycle 7 for 1 cycle. Separately, in READY, write 0x12345678 to 0x0010, then reset.
   - Required: `rdy` remains 1 and falls exactly 16 edges after release; read 0x0010 gives 0x110.
6. Pipelined reads:
   - Stimulus: addresses 0x00, 0x04, 0x08, 0x0C on consecutive edges.
   - Required: `q` shows 0x100, 0x104, 0x108, 0x10C on consecutive cycles, each one edge after its address.
